// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the Titan pipeline controller: forwarding codes, next-PC codes and
// the sequencing FSM states.
package pipeline_ctrl_pkg;

    localparam logic [1:0] FwdRf  = 2'b00;
    localparam logic [1:0] FwdEx  = 2'b01;
    localparam logic [1:0] FwdMem = 2'b10;
    localparam logic [1:0] FwdWb  = 2'b11;

    localparam logic [1:0] PcAdd4   = 2'b00;
    localparam logic [1:0] PcTarget = 2'b01;
    localparam logic [1:0] PcTrap   = 2'b10;
    localparam logic [1:0] PcEpc    = 2'b11;

    localparam int unsigned WaitCntW = 16;

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StMemWait = 2'b01,
        StTrap    = 2'b10
    } state_e;

    // Wait-counter value present during the stalled cycle that carries bus_error.
    // The request cycle in RUN is stalled cycle 1 (count 0), so the earliest reachable mark is 1.
    function automatic logic [WaitCntW-1:0] timeout_mark(input int unsigned timeout);
        if (timeout < 2) begin
            return WaitCntW'(1);
        end
        return WaitCntW'(timeout - 1);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_forward_unit.sv
// Operand forwarding select for one ID-stage source register, plus the load-use hit for it.
module pipeline_ctrl_forward_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic       uses,
    input  logic [4:0] ex_waddr,
    input  logic       ex_we,
    input  logic       ex_mem_read,
    input  logic [4:0] mem_waddr,
    input  logic       mem_we,
    input  logic [4:0] wb_address,
    input  logic       wb_we,
    output logic [1:0] sel,
    output logic       load_hazard
);

    logic rs_live;
    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    assign rs_live = uses && (rs != 5'd0);
    assign ex_hit  = rs_live && ex_we  && (ex_waddr   == rs);
    assign mem_hit = rs_live && mem_we && (mem_waddr  == rs);
    assign wb_hit  = rs_live && wb_we  && (wb_address == rs);

    // rs is non-zero here, so a hit also implies a non-zero load destination.
    assign load_hazard = ex_hit && ex_mem_read;

    always_comb begin
        sel = FwdRf;
        if (ex_hit && !ex_mem_read) begin
            sel = FwdEx;
        end else if (mem_hit) begin
            sel = FwdMem;
        end else if (wb_hit) begin
            sel = FwdWb;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stalls, flushes, forwarding,
// next-PC select and the RUN / MEM_WAIT / TRAP sequencer.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_waddr,
    input  logic [4:0] mem_waddr,
    input  logic [4:0] wb_address,
    input  logic       ex_we,
    input  logic       mem_we,
    input  logic       wb_we,
    input  logic       ex_mem_read,
    input  logic       branch_taken,
    input  logic       jump_op,
    input  logic       exception,
    input  logic       eret,
    input  logic       imem_ready,
    input  logic       dmem_req,
    input  logic       dmem_ready,
    output logic       if_stall,
    output logic       id_stall,
    output logic       ex_stall,
    output logic       mem_stall,
    output logic       if_flush,
    output logic       id_flush,
    output logic       ex_flush,
    output logic       mem_flush,
    output logic [1:0] forward_a_sel,
    output logic [1:0] forward_b_sel,
    output logic [1:0] pc_sel,
    output logic       bus_error,
    output logic       trap_active
);

    localparam logic [WaitCntW-1:0] TimeoutMark = timeout_mark(TIMEOUT);

    state_e              state_q;
    logic [WaitCntW-1:0] wait_cnt_q;
    logic [WaitCntW-1:0] wait_cnt_inc;
    logic [1:0]          trap_cnt_q;

    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       hazard_a;
    logic       hazard_b;
    logic       load_use;
    logic       mem_miss;

    // Stage vectors are ordered {if, id, ex, mem}.
    logic [3:0] raw_stall;
    logic [3:0] raw_flush;

    pipeline_ctrl_forward_unit u_fwd_a (
        .rs          (id_rs1),
        .uses        (id_uses_rs1),
        .ex_waddr    (ex_waddr),
        .ex_we       (ex_we),
        .ex_mem_read (ex_mem_read),
        .mem_waddr   (mem_waddr),
        .mem_we      (mem_we),
        .wb_address  (wb_address),
        .wb_we       (wb_we),
        .sel         (fwd_a),
        .load_hazard (hazard_a)
    );

    pipeline_ctrl_forward_unit u_fwd_b (
        .rs          (id_rs2),
        .uses        (id_uses_rs2),
        .ex_waddr    (ex_waddr),
        .ex_we       (ex_we),
        .ex_mem_read (ex_mem_read),
        .mem_waddr   (mem_waddr),
        .mem_we      (mem_we),
        .wb_address  (wb_address),
        .wb_we       (wb_we),
        .sel         (fwd_b),
        .load_hazard (hazard_b)
    );

    assign load_use     = hazard_a || hazard_b;
    assign mem_miss     = dmem_req && !dmem_ready;
    assign wait_cnt_inc = wait_cnt_q + WaitCntW'(1);

    assign forward_a_sel = rst ? FwdRf : fwd_a;
    assign forward_b_sel = rst ? FwdRf : fwd_b;

    // bus_error is registered, so the timeout is committed one cycle ahead; the pulse cycle
    // stays stalled and always leads into TRAP even if dmem_ready shows up in it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            wait_cnt_q  <= '0;
            trap_cnt_q  <= 2'd0;
            bus_error   <= 1'b0;
            trap_active <= 1'b0;
        end else begin
            bus_error <= 1'b0;
            unique case (state_q)
                StRun: begin
                    if (exception) begin
                        state_q     <= StTrap;
                        trap_cnt_q  <= 2'd0;
                        trap_active <= 1'b1;
                    end else if (mem_miss) begin
                        state_q    <= StMemWait;
                        wait_cnt_q <= WaitCntW'(1);
                        bus_error  <= (TimeoutMark == WaitCntW'(1));
                    end
                end
                StMemWait: begin
                    if (bus_error) begin
                        state_q     <= StTrap;
                        wait_cnt_q  <= '0;
                        trap_cnt_q  <= 2'd0;
                        trap_active <= 1'b1;
                    end else if (dmem_ready) begin
                        state_q    <= StRun;
                        wait_cnt_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_inc;
                        bus_error  <= (wait_cnt_inc == TimeoutMark);
                    end
                end
                StTrap: begin
                    if (trap_cnt_q == 2'd1) begin
                        state_q     <= StRun;
                        trap_cnt_q  <= 2'd0;
                        trap_active <= 1'b0;
                    end else begin
                        trap_cnt_q <= trap_cnt_q + 2'd1;
                    end
                end
                default: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

    always_comb begin
        raw_stall = 4'b0000;
        raw_flush = 4'b0000;
        pc_sel    = PcAdd4;
        if (rst) begin
            raw_flush = 4'b1111;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (exception) begin
                        pc_sel    = PcTrap;
                        raw_flush = 4'b1111;
                    end else if (mem_miss) begin
                        raw_stall = 4'b1111;
                    end else if (branch_taken) begin
                        pc_sel    = PcTarget;
                        raw_flush = 4'b1100;
                    end else if (eret) begin
                        pc_sel    = PcEpc;
                        raw_flush = 4'b1000;
                    end else if (jump_op) begin
                        pc_sel    = PcTarget;
                        raw_flush = 4'b1000;
                    end else if (load_use) begin
                        raw_stall = 4'b1100;
                        raw_flush = 4'b0010;
                    end else if (!imem_ready) begin
                        raw_stall = 4'b1000;
                        raw_flush = 4'b0100;
                    end
                end
                StMemWait: begin
                    if (bus_error || !dmem_ready) begin
                        raw_stall = 4'b1111;
                    end
                end
                StTrap: begin
                    pc_sel    = PcTrap;
                    raw_flush = 4'b1110;
                end
                default: begin
                    raw_stall = 4'b0000;
                end
            endcase
        end
    end

    // Flush wins over stall on any stage.
    assign if_stall  = raw_stall[3] && !raw_flush[3];
    assign id_stall  = raw_stall[2] && !raw_flush[2];
    assign ex_stall  = raw_stall[1] && !raw_flush[1];
    assign mem_stall = raw_stall[0] && !raw_flush[0];

    assign if_flush  = raw_flush[3];
    assign id_flush  = raw_flush[2];
    assign ex_flush  = raw_flush[1];
    assign mem_flush = raw_flush[0];

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a table of combinational RUN-state vectors plus hand-written
// multi-cycle sequences for load-use, memory wait, timeout, trap and reset.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_waddr, mem_waddr, wb_address;
    logic       id_uses_rs1, id_uses_rs2, ex_we, mem_we, wb_we, ex_mem_read;
    logic       branch_taken, jump_op, exception, eret, imem_ready, dmem_req, dmem_ready;

    logic       if_stall, id_stall, ex_stall, mem_stall;
    logic       if_flush, id_flush, ex_flush, mem_flush;
    logic [1:0] forward_a_sel, forward_b_sel, pc_sel;
    logic       bus_error, trap_active;

    logic       t_if_stall, t_id_stall, t_ex_stall, t_mem_stall;
    logic       t_if_flush, t_id_flush, t_ex_flush, t_mem_flush;
    logic [1:0] t_forward_a_sel, t_forward_b_sel, t_pc_sel;
    logic       t_bus_error, t_trap_active;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_waddr(ex_waddr), .mem_waddr(mem_waddr), .wb_address(wb_address),
        .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we), .ex_mem_read(ex_mem_read),
        .branch_taken(branch_taken), .jump_op(jump_op), .exception(exception), .eret(eret),
        .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
        .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
        .forward_a_sel(forward_a_sel), .forward_b_sel(forward_b_sel), .pc_sel(pc_sel),
        .bus_error(bus_error), .trap_active(trap_active)
    );

    pipeline_ctrl #(.TIMEOUT(4)) dut_t4 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_waddr(ex_waddr), .mem_waddr(mem_waddr), .wb_address(wb_address),
        .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we), .ex_mem_read(ex_mem_read),
        .branch_taken(branch_taken), .jump_op(jump_op), .exception(exception), .eret(eret),
        .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .if_stall(t_if_stall), .id_stall(t_id_stall), .ex_stall(t_ex_stall),
        .mem_stall(t_mem_stall), .if_flush(t_if_flush), .id_flush(t_id_flush),
        .ex_flush(t_ex_flush), .mem_flush(t_mem_flush),
        .forward_a_sel(t_forward_a_sel), .forward_b_sel(t_forward_b_sel), .pc_sel(t_pc_sel),
        .bus_error(t_bus_error), .trap_active(t_trap_active)
    );

    logic [3:0]  stl, fls, t_stl, t_fls;
    logic [13:0] got;
    assign stl   = {if_stall, id_stall, ex_stall, mem_stall};
    assign fls   = {if_flush, id_flush, ex_flush, mem_flush};
    assign t_stl = {t_if_stall, t_id_stall, t_ex_stall, t_mem_stall};
    assign t_fls = {t_if_flush, t_id_flush, t_ex_flush, t_mem_flush};
    assign got   = {stl, fls, forward_a_sel, forward_b_sel, pc_sel};

    typedef struct {
        logic [4:0] rs1, rs2;
        logic [1:0] uses;    // {rs1, rs2}
        logic [4:0] exa, mema, wba;
        logic [3:0] we_rd;   // {ex_we, mem_we, wb_we, ex_mem_read}
        logic [5:0] ctl;     // {branch, jump, eret, imem_ready, dmem_req, dmem_ready}
        logic [3:0] stall, flush;
        logic [1:0] fa, fb, pc;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [1:0] uses, input logic [4:0] exa,
                                input logic [4:0] mema, input logic [4:0] wba,
                                input logic [3:0] we_rd, input logic [5:0] ctl,
                                input logic [3:0] stall, input logic [3:0] flush,
                                input logic [1:0] fa, input logic [1:0] fb,
                                input logic [1:0] pc);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.uses = uses; v.exa = exa; v.mema = mema; v.wba = wba;
        v.we_rd = we_rd; v.ctl = ctl; v.stall = stall; v.flush = flush;
        v.fa = fa; v.fb = fb; v.pc = pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_waddr = 5'd0; mem_waddr = 5'd0; wb_address = 5'd0;
        ex_we = 1'b0; mem_we = 1'b0; wb_we = 1'b0; ex_mem_read = 1'b0;
        branch_taken = 1'b0; jump_op = 1'b0; exception = 1'b0; eret = 1'b0;
        imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; {id_uses_rs1, id_uses_rs2} = v.uses;
        ex_waddr = v.exa; mem_waddr = v.mema; wb_address = v.wba;
        {ex_we, mem_we, wb_we, ex_mem_read} = v.we_rd;
        {branch_taken, jump_op, eret, imem_ready, dmem_req, dmem_ready} = v.ctl;
        exception = 1'b0;
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[19];

    initial begin
        vecs[0]  = mk(5, 0, 2'b10, 5, 5, 0, 4'b1100, 6'b000100, 4'h0, 4'h0, 2'b01, 2'b00, 2'b00);
        vecs[1]  = mk(0, 0, 2'b10, 0, 0, 0, 4'b1110, 6'b000100, 4'h0, 4'h0, 2'b00, 2'b00, 2'b00);
        vecs[2]  = mk(5, 0, 2'b10, 5, 5, 0, 4'b0100, 6'b000100, 4'h0, 4'h0, 2'b10, 2'b00, 2'b00);
        vecs[3]  = mk(0, 9, 2'b01, 0, 0, 9, 4'b0010, 6'b000100, 4'h0, 4'h0, 2'b00, 2'b11, 2'b00);
        vecs[4]  = mk(3, 3, 2'b00, 3, 3, 3, 4'b1110, 6'b000100, 4'h0, 4'h0, 2'b00, 2'b00, 2'b00);
        vecs[5]  = mk(6, 4, 2'b11, 4, 6, 0, 4'b1100, 6'b000100, 4'h0, 4'h0, 2'b10, 2'b01, 2'b00);
        vecs[6]  = mk(0, 7, 2'b01, 7, 0, 0, 4'b1001, 6'b000100, 4'hC, 4'h2, 2'b00, 2'b00, 2'b00);
        vecs[7]  = mk(7, 0, 2'b10, 7, 7, 0, 4'b1101, 6'b000100, 4'hC, 4'h2, 2'b10, 2'b00, 2'b00);
        vecs[8]  = mk(0, 0, 2'b10, 0, 0, 0, 4'b1001, 6'b000100, 4'h0, 4'h0, 2'b00, 2'b00, 2'b00);
        vecs[9]  = mk(0, 7, 2'b01, 7, 0, 0, 4'b1001, 6'b100100, 4'h0, 4'hC, 2'b00, 2'b00, 2'b01);
        vecs[10] = mk(0, 0, 2'b00, 0, 0, 0, 4'b0000, 6'b010100, 4'h0, 4'h8, 2'b00, 2'b00, 2'b01);
        vecs[11] = mk(0, 0, 2'b00, 0, 0, 0, 4'b0000, 6'b001100, 4'h0, 4'h8, 2'b00, 2'b00, 2'b11);
        vecs[12] = mk(0, 0, 2'b00, 0, 0, 0, 4'b0000, 6'b111100, 4'h0, 4'hC, 2'b00, 2'b00, 2'b01);
        vecs[13] = mk(0, 0, 2'b00, 0, 0, 0, 4'b0000, 6'b011100, 4'h0, 4'h8, 2'b00, 2'b00, 2'b11);
        vecs[14] = mk(0, 0, 2'b00, 0, 0, 0, 4'b0000, 6'b000000, 4'h8, 4'h4, 2'b00, 2'b00, 2'b00);
        vecs[15] = mk(0, 0, 2'b00, 0, 0, 0, 4'b0000, 6'b010000, 4'h0, 4'h8, 2'b00, 2'b00, 2'b01);
        vecs[16] = mk(0, 7, 2'b01, 7, 0, 0, 4'b1001, 6'b000000, 4'hC, 4'h2, 2'b00, 2'b00, 2'b00);
        vecs[17] = mk(0, 0, 2'b00, 0, 0, 0, 4'b0000, 6'b000111, 4'h0, 4'h0, 2'b00, 2'b00, 2'b00);
        vecs[18] = mk(12, 12, 2'b11, 12, 0, 0, 4'b1000, 6'b000100, 4'h0, 4'h0, 2'b01, 2'b01, 2'b00);

        // Reset: outputs forced to reset values even with a live forwarding match.
        idle();
        rst = 1'b1;
        id_rs1 = 5'd5; id_uses_rs1 = 1'b1; ex_waddr = 5'd5; ex_we = 1'b1;
        next(); next();
        @(negedge clk);
        chk("reset_outputs", 32'(got), 32'({4'h0, 4'hF, 2'b00, 2'b00, 2'b00}));
        chk("reset_trap_active", 32'(trap_active), 32'd0);
        chk("reset_bus_error", 32'(bus_error), 32'd0);
        next();
        rst = 1'b0;
        idle();

        foreach (vecs[i]) begin
            next();
            apply(vecs[i]);
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(got),
                32'({vecs[i].stall, vecs[i].flush, vecs[i].fa, vecs[i].fb, vecs[i].pc}));
        end

        // Load-use: one stall cycle, then the load result comes from MEM.
        next(); idle();
        id_rs2 = 5'd7; id_uses_rs2 = 1'b1; ex_waddr = 5'd7; ex_we = 1'b1; ex_mem_read = 1'b1;
        @(negedge clk);
        chk("lu_stall", 32'({stl, fls}), 32'({4'hC, 4'h2}));
        next();
        ex_waddr = 5'd0; ex_we = 1'b0; ex_mem_read = 1'b0; mem_waddr = 5'd7; mem_we = 1'b1;
        @(negedge clk);
        chk("lu_fwd_mem", 32'(forward_b_sel), 32'd2);
        chk("lu_released", 32'({stl, fls}), 32'd0);

        // Three cycles of dmem_ready low: three all-stage stalls, exception ignored meanwhile.
        next(); idle();
        dmem_req = 1'b1;
        @(negedge clk);
        chk("mw_stall0", 32'(stl), 32'hF);
        next(); exception = 1'b1;
        @(negedge clk);
        chk("mw_stall1", 32'({stl, pc_sel}), 32'({4'hF, 2'b00}));
        next(); exception = 1'b0;
        @(negedge clk);
        chk("mw_stall2", 32'(stl), 32'hF);
        next(); dmem_ready = 1'b1;
        @(negedge clk);
        chk("mw_ready_free", 32'({stl, bus_error}), 32'd0);
        next(); idle();
        @(negedge clk);
        chk("mw_back_run", 32'({stl, bus_error, trap_active}), 32'd0);

        // Let the TIMEOUT=4 instance (which timed out above) finish its trap.
        repeat (4) next();

        // Timeout with TIMEOUT=4: bus_error in the 4th stalled cycle, then 2 TRAP cycles.
        next(); idle();
        dmem_req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("to_stall%0d", c), 32'({t_stl, t_bus_error, t_trap_active}),
                32'({4'hF, (c == 3), 1'b0}));
            next();
        end
        exception = 1'b1; eret = 1'b1;
        @(negedge clk);
        chk("to_trap1", 32'({t_trap_active, t_bus_error, t_pc_sel, t_stl, t_fls}),
            32'({1'b1, 1'b0, 2'b10, 4'h0, 4'hE}));
        next(); exception = 1'b0; eret = 1'b0;
        @(negedge clk);
        chk("to_trap2", 32'({t_trap_active, t_pc_sel}), 32'({1'b1, 2'b10}));
        next(); dmem_req = 1'b0; dmem_ready = 1'b1;
        @(negedge clk);
        chk("to_run", 32'({t_trap_active, t_pc_sel, t_fls}), 32'd0);
        next(); idle();

        // Exception beats branch; reset during the 2nd TRAP cycle.
        next(); exception = 1'b1; branch_taken = 1'b1;
        @(negedge clk);
        chk("exc_entry", 32'({pc_sel, fls, stl}), 32'({2'b10, 4'hF, 4'h0}));
        next(); idle();
        @(negedge clk);
        chk("trap_c1", 32'({trap_active, pc_sel, fls}), 32'({1'b1, 2'b10, 4'hE}));
        next();
        @(negedge clk);
        chk("trap_c2", 32'(trap_active), 32'd1);
        rst = 1'b1;
        next();
        @(negedge clk);
        chk("rst_in_trap", 32'({trap_active, bus_error, fls, stl, pc_sel}),
            32'({1'b0, 1'b0, 4'hF, 4'h0, 2'b00}));
        next(); rst = 1'b0;
        @(negedge clk);
        chk("run_after_rst", 32'({trap_active, fls, pc_sel}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the Titan 5-stage RV32 pipeline (IF, ID, EX, MEM, WB). It produces the per-stage stall and flush strobes, the ID-stage operand forwarding selects and the next-PC select. A small FSM sequences data-memory wait states, bus-timeout detection and trap entry/return.

## Interface
- TIMEOUT, 255: maximum data-memory wait cycles before a bus error (1..65535).
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- id_rs1, id_rs2  in  5  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1  the instruction in ID reads that source.
- ex_waddr, mem_waddr, wb_address  in  5  destination register in EX, MEM and WB.
- ex_we, mem_we, wb_we  in  1  write enable in EX, MEM and WB.
- ex_mem_read  in  1  the instruction in EX is a load.
- branch_taken  in  1  the branch in EX resolved taken.
- jump_op  in  1  jump decoded in ID.
- exception  in  1  OR of bad_jump_addr, bad_branch_addr, syscall_op, break_op and the illegal-instruction flag.
- eret  in  1  trap return decoded in ID.
- imem_ready  in  1  instruction fetch completes this cycle.
- dmem_req, dmem_ready  in  1  MEM-stage access request and its completion.
- if_stall, id_stall, ex_stall, mem_stall  out  1  hold the stage register.
- if_flush, id_flush, ex_flush, mem_flush  out  1  load a bubble into the stage register.
- forward_a_sel, forward_b_sel  out  2  operand source: 00 register file, 01 EX result, 10 MEM result, 11 wb_data.
- pc_sel  out  2  next PC: 00 pc_add4, 01 branch/jump target, 10 trap vector, 11 EPC.
- bus_error  out  1  one-cycle pulse on data-memory timeout.
- trap_active  out  1  high while the FSM is in TRAP.

## Operation
- FSM states: RUN, MEM_WAIT, TRAP. Reset state is RUN.
- Reset values: state RUN, wait counter 0, bus_error 0, trap_active 0, all stalls 0, all flushes 1, pc_sel 00, forward selects 00.
- Forwarding (combinational, one select per port):
  - Priority EX > MEM > WB.
  - A stage matches when it has we=1, waddr==rs, rs!=0 and the ID instruction uses that source.
  - A load in EX never selects 01.
- Load-use interlock (RUN only): ex_mem_read, ex_waddr!=0 and a match on a used source give if_stall=1, id_stall=1, ex_flush=1 for exactly one cycle.
- Control transfer (RUN):
  - branch_taken gives pc_sel=01, if_flush=1, id_flush=1, and overrides load-use.
  - If there is no branch_taken, jump_op gives pc_sel=01 and if_flush=1.
  - eret gives pc_sel=11 and if_flush=1.
- Fetch miss: imem_ready=0 gives if_stall=1 and id_flush=1. Stateless.
- MEM_WAIT:
  - Entered from RUN when dmem_req=1 and dmem_ready=0.
  - All four stalls are 1 and the counter increments every cycle.
  - dmem_ready=1 returns to RUN and clears the counter.
  - Counter == TIMEOUT-1 without ready: bus_error=1 for that cycle, then go to TRAP.
- TRAP:
  - Entered from RUN on exception, or from a MEM_WAIT timeout.
  - On entry cycle (RUN with exception): pc_sel=10 and if/id/ex/mem_flush=1 in the same cycle.
  - TRAP lasts exactly 2 cycles (2-bit counter). if/id/ex_flush stay 1 and exception/eret are ignored.
  - Then return to RUN.
- Priority, highest first: rst > exception/timeout > MEM_WAIT > branch_taken > eret > jump_op > load-use > fetch miss.
- A stage never sees stall and flush together; flush wins.

## Timing
- Forwarding selects, stalls, flushes and pc_sel are combinational from the inputs and the current state. Zero latency.
- State, counters, bus_error and trap_active are registered.
- Load-use stall lasts 1 cycle; the dependent instruction receives forward_sel=10 on the next cycle.
- MEM_WAIT adds N stall cycles for N cycles of dmem_ready=0. The dmem_ready cycle itself is not stalled.
- Timeout: bus_error is asserted in the TIMEOUT-th stalled cycle, and TRAP_active follows on the next edge.
- exception during MEM_WAIT is ignored. The pending MEM access completes first.
- rst asserted mid-MEM_WAIT or mid-TRAP gives the reset values at the next edge.

## Structure
- Shared header `titan_defs.vh` holds:
  - FWD_RF/EX/MEM/WB codes;
  - PCSEL_ADD4/TARGET/TRAP/EPC;
  - FSM state encodings.
- Sub-module `forward_unit`: purely combinational, instantiated once per source port (rs1 and rs2).

## Test plan
- EX writes x5 and MEM writes x5, ID reads rs1=x5 -> forward_a_sel=01. Same case with rs1=x0 -> forward_a_sel=00.
- Load to x7 in EX, ID uses rs2=x7 -> one cycle of if_stall=id_stall=ex_flush=1, then forward_b_sel=10.
- dmem_req with dmem_ready low for 3 cycles -> 3 cycles of all-stage stall, back to RUN, no bus_error.
- TIMEOUT=4, dmem_ready held low -> bus_error pulse in the 4th stall cycle, trap_active=1 for 2 cycles, pc_sel=10 is never 01 during the trap.
- exception and branch_taken in the same cycle -> pc_sel=10 and all flushes 1, no branch redirect.
- rst in the 2nd TRAP cycle -> next cycle state RUN, trap_active=0, all flushes 1.
